// File: rtl/simple_spi_target.sv
// simple_spi_target: SPI mode-0 target. Oversamples CSn/SCK/MOSI in the system clock
// domain, assembles MOSI bytes for the fabric and shifts fabric bytes onto MISO MSB-first.
// Optional status flags (underrun_o, frame_err_o) are built only when
// SIMPLE_SPI_TARGET_STATUS_EN is defined; otherwise they read as 0.
module simple_spi_target #(
   parameter logic [7:0]  FILL_BYTE   = 8'hFF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       spi_csn,
   input  logic       spi_sck,
   input  logic       spi_mosi,
   output logic       spi_miso_o,
   output logic       spi_miso_t,
   input  logic [7:0] tx_data_i,
   input  logic       tx_load_i,
   output logic       tx_ready_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       rx_first_o,
   output logic       underrun_o,
   output logic       frame_err_o,
   input  logic       status_clr_i
);

   typedef enum logic {StIdle, StActive} state_e;

   // Synchroniser chains, newest sample in bit 0
   logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   csn_prev_q, csn_prev_d;
   logic                   sck_prev_q, sck_prev_d;

   state_e     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] hold_q, hold_d;
   logic       tx_ready_q, tx_ready_d;
   logic       boundary_q, boundary_d;
   logic       first_q, first_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       rx_first_q, rx_first_d;
   logic       miso_q, miso_d;
   logic       miso_t_q, miso_t_d;

   logic       csn_s, sck_s, mosi_s;
   logic       csn_fall, csn_rise, sck_rise, sck_fall;
   logic       reload;
   logic       underrun_set, frame_err_set;
   logic [7:0] rx_next;

   assign csn_s    = csn_sync_q[SYNC_STAGES-1];
   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign csn_fall = csn_prev_q & ~csn_s;
   assign csn_rise = ~csn_prev_q & csn_s;
   assign sck_rise = ~sck_prev_q & sck_s;
   assign sck_fall = sck_prev_q & ~sck_s;
   assign rx_next  = {rx_shift_q[6:0], mosi_s};

   // Synchroniser shift and edge-detect history
   always_comb begin
      csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      csn_prev_d  = csn_s;
      sck_prev_d  = sck_s;
   end

   // Frame FSM, RX assembly, TX shifting and holding-register handshake
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      rx_shift_d    = rx_shift_q;
      tx_shift_d    = tx_shift_q;
      hold_d        = hold_q;
      tx_ready_d    = tx_ready_q;
      boundary_d    = boundary_q;
      first_d       = first_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      rx_first_d    = rx_first_q;
      reload        = 1'b0;
      underrun_set  = 1'b0;
      frame_err_set = 1'b0;

      unique case (state_q)
         StIdle: begin
            bit_cnt_d  = 3'd0;
            boundary_d = 1'b0;
            if (csn_fall) begin
               state_d = StActive;
               reload  = 1'b1;
               first_d = 1'b1;
            end
         end
         StActive: begin
            if (csn_rise) begin
               // A partial byte is dropped without a valid pulse
               state_d       = StIdle;
               bit_cnt_d     = 3'd0;
               boundary_d    = 1'b0;
               frame_err_set = (bit_cnt_q != 3'd0);
            end else if (sck_rise) begin
               rx_shift_d = rx_next;
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_data_d  = rx_next;
                  rx_valid_d = 1'b1;
                  rx_first_d = first_q;
                  first_d    = 1'b0;
                  boundary_d = 1'b1;
               end
            end else if (sck_fall) begin
               if (boundary_q) begin
                  reload     = 1'b1;
                  boundary_d = 1'b0;
               end else begin
                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Reload takes the holding register if full, otherwise the fill byte
      if (reload) begin
         if (!tx_ready_q) begin
            tx_shift_d = hold_q;
            tx_ready_d = 1'b1;
         end else begin
            tx_shift_d   = FILL_BYTE;
            underrun_set = 1'b1;
         end
      end

      // Only accepted when empty, so never collides with a reload from the holding register
      if (tx_load_i && tx_ready_q) begin
         hold_d     = tx_data_i;
         tx_ready_d = 1'b0;
      end

      miso_t_d = (state_q != StActive);
      miso_d   = (state_q == StActive) ? tx_shift_q[7] : 1'b0;
   end

   // State registers; CSn history resets low so a held-low CSn is not taken as a fall
   always_ff @(posedge clock) begin
      if (rst) begin
         csn_sync_q  <= '0;
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         csn_prev_q  <= 1'b0;
         sck_prev_q  <= 1'b0;
         state_q     <= StIdle;
         bit_cnt_q   <= 3'd0;
         rx_shift_q  <= 8'h00;
         tx_shift_q  <= 8'h00;
         hold_q      <= 8'h00;
         tx_ready_q  <= 1'b1;
         boundary_q  <= 1'b0;
         first_q     <= 1'b0;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         rx_first_q  <= 1'b0;
         miso_q      <= 1'b0;
         miso_t_q    <= 1'b1;
      end else begin
         csn_sync_q  <= csn_sync_d;
         sck_sync_q  <= sck_sync_d;
         mosi_sync_q <= mosi_sync_d;
         csn_prev_q  <= csn_prev_d;
         sck_prev_q  <= sck_prev_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         hold_q      <= hold_d;
         tx_ready_q  <= tx_ready_d;
         boundary_q  <= boundary_d;
         first_q     <= first_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         rx_first_q  <= rx_first_d;
         miso_q      <= miso_d;
         miso_t_q    <= miso_t_d;
      end
   end

   assign spi_miso_o = miso_q;
   assign spi_miso_t = miso_t_q;
   assign tx_ready_o = tx_ready_q;
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign rx_first_o = rx_first_q;

`ifdef SIMPLE_SPI_TARGET_STATUS_EN
   logic underrun_q, underrun_d;
   logic frame_err_q, frame_err_d;

   // Sticky flags; a set in the same cycle as a clear wins
   always_comb begin
      underrun_d  = (underrun_q & ~status_clr_i) | underrun_set;
      frame_err_d = (frame_err_q & ~status_clr_i) | frame_err_set;
   end

   // Status flag registers
   always_ff @(posedge clock) begin
      if (rst) begin
         underrun_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         underrun_q  <= underrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign underrun_o  = underrun_q;
   assign frame_err_o = frame_err_q;
`else
   logic unused_status;
   assign unused_status = ^{underrun_set, frame_err_set, status_clr_i};
   assign underrun_o    = 1'b0;
   assign frame_err_o   = 1'b0;
`endif

endmodule
